// File: rtl/channel_demux_pkg.sv
// Shared types and constants for the router input-stage channel demux.
package channel_demux_pkg;

  localparam int unsigned ROUTER_FLIT_W = 11;

  // Occupancy flags reported by each output buffer.
  typedef struct packed {
    logic full;
    logic empty;
  } fifo_stat_t;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/channel_demux_if.sv
// Valid/ready stream channel; master drives data and valid, slave drives ready.
interface channel_demux_if
  import channel_demux_pkg::*;
#(
  parameter int unsigned WIDTH = ROUTER_FLIT_W
) ();

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/channel_demux_chan_fifo.sv
// Per-output flit buffer; flags come from the registered count only.
module chan_fifo
  import channel_demux_pkg::*;
#(
  parameter int unsigned WIDTH = ROUTER_FLIT_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A pop on a full buffer does not free a slot for a push in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and count; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/channel_demux.sv
// Joins a flit (A) with a route select (C) and steers it into the X or Y buffer.
module channel_demux
  import channel_demux_pkg::*;
#(
  parameter int unsigned WIDTH = ROUTER_FLIT_W,
  parameter int unsigned DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  channel_demux_if.slave   a,
  channel_demux_if.slave   c,
  channel_demux_if.master  x,
  channel_demux_if.master  y
);

  fifo_stat_t x_stat;
  fifo_stat_t y_stat;
  logic       sel_full;
  logic       accept;
  logic       x_push;
  logic       y_push;

  // A and C are consumed together only when the selected buffer has room.
  assign sel_full = c.data[0] ? y_stat.full : x_stat.full;
  assign a.ready  = c.valid & ~sel_full;
  assign c.ready  = a.valid & ~sel_full;
  assign accept   = a.valid & c.valid & ~sel_full;
  assign x_push   = accept & ~c.data[0];
  assign y_push   = accept &  c.data[0];

  assign x.valid  = ~x_stat.empty;
  assign y.valid  = ~y_stat.empty;

  chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_x_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (x_push),
    .din   (a.data),
    .full  (x_stat.full),
    .pop   (x.ready),
    .dout  (x.data),
    .empty (x_stat.empty)
  );

  chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_y_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (y_push),
    .din   (a.data),
    .full  (y_stat.full),
    .pop   (y.ready),
    .dout  (y.data),
    .empty (y_stat.empty)
  );

endmodule
